// File: rtl/systolic_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared types and elaboration helpers for the systolic array job sequencer.
//   - seq_state_e : sequencer FSM states
//   - elems_f     : number of operand/result words per pass (columns * rows)
//   - cnt_w_f     : bit width needed to hold the values 0..n
// -----------------------------------------------------------------------------
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    WAIT_A = 3'd2,
    LOAD_B = 3'd3,
    WAIT_B = 3'd4,
    FLUSH  = 3'd5,
    DRAIN  = 3'd6,
    DONE   = 3'd7
  } seq_state_e;

  function automatic int elems_f(input int w, input int h);
    return w * h;
  endfunction

  // Width able to represent 0..n inclusive; never less than one bit.
  function automatic int cnt_w_f(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl_if
//   Bundles the three streaming ports of the sequencer. Signal suffixes are
//   from the sequencer's point of view (_i = into sequencer, _o = out of it).
//   Host side   : host_valid_i, host_ready_o, host_data_i
//   Array load  : arr_valid_o, arr_ready_i, arr_data_o
//   Array ctrl  : arr_busy_i, arr_flush_o
//   Array drain : arr_valid_i, arr_data_i, arr_yumi_o
//   Result side : res_valid_o, res_ready_i, res_data_o
//   Modports: master = sequencer, slave = surrounding host/array/sink.
// -----------------------------------------------------------------------------
interface systolic_seq_ctrl_if #(
  parameter int width_p = 8
) ();

  logic               host_valid_i;
  logic               host_ready_o;
  logic [width_p-1:0] host_data_i;
  logic               arr_valid_o;
  logic               arr_ready_i;
  logic [width_p-1:0] arr_data_o;
  logic               arr_busy_i;
  logic               arr_flush_o;
  logic               arr_valid_i;
  logic [width_p-1:0] arr_data_i;
  logic               arr_yumi_o;
  logic               res_valid_o;
  logic               res_ready_i;
  logic [width_p-1:0] res_data_o;

  modport master (
    input  host_valid_i, host_data_i, arr_ready_i, arr_busy_i,
           arr_valid_i, arr_data_i, res_ready_i,
    output host_ready_o, arr_valid_o, arr_data_o, arr_flush_o,
           arr_yumi_o, res_valid_o, res_data_o
  );

  modport slave (
    output host_valid_i, host_data_i, arr_ready_i, arr_busy_i,
           arr_valid_i, arr_data_i, res_ready_i,
    input  host_ready_o, arr_valid_o, arr_data_o, arr_flush_o,
           arr_yumi_o, res_valid_o, res_data_o
  );

endinterface

// File: rtl/systolic_seq_ctrl_counter.sv
// -----------------------------------------------------------------------------
// systolic_seq_counter
//   Clear/increment up-counter with a terminal-count flag.
//   clk_i    : clock
//   reset_ni : asynchronous active-low reset
//   clr_i    : synchronous clear (wins over inc_i)
//   inc_i    : count one event
//   last_o   : inc_i is counting event number limit_p (count reaches limit_p)
// -----------------------------------------------------------------------------
module systolic_seq_counter
  import systolic_pkg::*;
#(
  parameter int limit_p = 4
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam int               cw_lp       = cnt_w_f(limit_p);
  localparam logic [cw_lp-1:0] last_val_lp = cw_lp'(limit_p - 1);

  logic [cw_lp-1:0] count_q;
  logic [cw_lp-1:0] count_d;

  // Next count: clear has priority so a terminal event also restarts from 0.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {cw_lp{1'b0}};
    end else if (inc_i) begin
      count_d = count_q + cw_lp'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= {cw_lp{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = inc_i & (count_q == last_val_lp);

endmodule

// File: rtl/systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl
//   Job sequencer for systolic_array: per start_i, streams elems host words
//   into the array (pass A), waits for the array to go idle, streams elems
//   more (pass B), waits again, pulses flush, then drains elems results.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   start_i         : start a job (sampled in IDLE only)
//   busy_o          : high in every state except IDLE
//   done_o          : registered one-cycle pulse at job completion
//   err_o           : sticky timeout flag
//   bus             : host / array / result streams (systolic_seq_ctrl_if)
//   Optional feature: define SYSTOLIC_SEQ_TIMEOUT_EN to bound WAIT_A/WAIT_B/
//   DRAIN by timeout_p cycles; without it err_o is tied low and waits are
//   unbounded.
// -----------------------------------------------------------------------------
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int width_p        = 8,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int timeout_p      = 64
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  output logic err_o,
  systolic_seq_ctrl_if.master bus
);

  localparam int elems_lp = elems_f(array_width_p, array_height_p);

  if (timeout_p < 2) begin : g_bad_timeout_p
    $error("systolic_seq_ctrl: timeout_p must be at least 2");
  end

  seq_state_e state_q;
  seq_state_e state_d;
  logic       done_q;
  logic       load_s;
  logic       drain_s;
  logic       xfer_s;
  logic       pop_s;
  logic       elem_clr_s;
  logic       elem_inc_s;
  logic       elem_last_s;
  logic       timeout_s;

  assign load_s  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign drain_s = (state_q == DRAIN);
  assign xfer_s  = load_s & bus.host_valid_i & bus.arr_ready_i;
  assign pop_s   = drain_s & bus.arr_valid_i & bus.res_ready_i;

  // Streaming datapath: zero-latency pass-through while loading/draining.
  always_comb begin
    bus.host_ready_o = 1'b0;
    bus.arr_valid_o  = 1'b0;
    bus.arr_data_o   = {width_p{1'b0}};
    bus.res_valid_o  = 1'b0;
    bus.res_data_o   = {width_p{1'b0}};
    bus.arr_yumi_o   = 1'b0;
    bus.arr_flush_o  = (state_q == FLUSH);
    if (load_s) begin
      bus.host_ready_o = bus.arr_ready_i;
      bus.arr_valid_o  = bus.host_valid_i;
      bus.arr_data_o   = bus.host_data_i;
    end else begin
      bus.host_ready_o = 1'b0;
      bus.arr_valid_o  = 1'b0;
      bus.arr_data_o   = {width_p{1'b0}};
    end
    if (drain_s) begin
      bus.res_valid_o = bus.arr_valid_i;
      bus.res_data_o  = bus.arr_data_i;
      bus.arr_yumi_o  = bus.arr_valid_i & bus.res_ready_i;
    end else begin
      bus.res_valid_o = 1'b0;
      bus.res_data_o  = {width_p{1'b0}};
      bus.arr_yumi_o  = 1'b0;
    end
  end

  // Next-state logic. In WAIT/DRAIN a normal exit wins over a timeout that
  // lands on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = LOAD_A;
        else         state_d = IDLE;
      end
      LOAD_A: begin
        if (elem_last_s) state_d = WAIT_A;
        else             state_d = LOAD_A;
      end
      WAIT_A: begin
        if (!bus.arr_busy_i) state_d = LOAD_B;
        else if (timeout_s)  state_d = IDLE;
        else                 state_d = WAIT_A;
      end
      LOAD_B: begin
        if (elem_last_s) state_d = WAIT_B;
        else             state_d = LOAD_B;
      end
      WAIT_B: begin
        if (!bus.arr_busy_i) state_d = FLUSH;
        else if (timeout_s)  state_d = IDLE;
        else                 state_d = WAIT_B;
      end
      FLUSH: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        if (elem_last_s)    state_d = DONE;
        else if (timeout_s) state_d = IDLE;
        else                state_d = DRAIN;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The element counter is shared by both load passes and the drain; it
  // restarts on every state change so it can never wrap.
  assign elem_clr_s = (state_d != state_q);
  assign elem_inc_s = xfer_s | pop_s;

  systolic_seq_counter #(
    .limit_p (elems_lp)
  ) u_elem_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (elem_clr_s),
    .inc_i    (elem_inc_s),
    .last_o   (elem_last_s)
  );

`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
  logic timer_clr_s;
  logic timer_inc_s;
  logic timeout_exit_s;
  logic err_q;
  logic err_d;

  // Timer runs only while waiting on the array; each drained word restarts it.
  assign timer_inc_s = (state_q == WAIT_A) || (state_q == WAIT_B) || drain_s;
  assign timer_clr_s = (state_d != state_q) | pop_s;

  systolic_seq_counter #(
    .limit_p (timeout_p)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (timer_clr_s),
    .inc_i    (timer_inc_s),
    .last_o   (timeout_s)
  );

  // Only a timeout takes WAIT/DRAIN straight back to IDLE.
  assign timeout_exit_s = timer_inc_s && (state_d == IDLE);

  // Sticky error: set on timeout, cleared when the next job is accepted.
  always_comb begin
    err_d = err_q;
    if (timeout_exit_s) begin
      err_d = 1'b1;
    end else if ((state_q == IDLE) && start_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign timeout_s = 1'b0;
  assign err_o     = 1'b0;
`endif

  // State register and the done pulse, which is high exactly while in DONE.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
module tb_systolic_seq_ctrl;

  localparam int W  = 8;
  localparam int E  = 4;
  localparam int TO = 64;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  typedef logic [W-1:0] word_t;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  logic start_i = 1'b0;
  logic busy_o, done_o, err_o;

  systolic_seq_ctrl_if #(.width_p(W)) bus ();

  systolic_seq_ctrl #(
    .width_p(W), .array_width_p(2), .array_height_p(2), .timeout_p(TO)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard / model state (phase numbers follow the job order:
  // 0 idle, 1 pass A, 2 wait A, 3 pass B, 4 wait B, 5 flush, 6 drain, 7 done)
  word_t job_words[$], host_q[$], stub_rx[$], res_src[$], res_got[$];
  int    ph = 0, cnt = 0, tcnt = 0, busy_cnt = 0, res_idx = 0, done_cnt = 0, xfer_cnt = 0;
  bit    exp_err = 1'b0, stub_has_res = 1'b0;

  function automatic bit same_q(input word_t a[$], input word_t b[$]);
    if (a.size() != b.size()) return 1'b0;
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic idle_inputs();
    start_i = 1'b0;
    bus.host_valid_i = 1'b0; bus.host_data_i = '0;
    bus.arr_ready_i = 1'b0;  bus.arr_busy_i = 1'b0;
    bus.arr_valid_i = 1'b0;  bus.arr_data_i = '0;
    bus.res_ready_i = 1'b0;
  endtask

  task automatic new_job(input bit rnd);
    job_words.delete(); res_src.delete();
    for (int i = 0; i < 2 * E; i++) job_words.push_back(rnd ? word_t'($urandom) : word_t'(i));
    for (int i = 0; i < E; i++) res_src.push_back(word_t'($urandom));
  endtask

  // Drives one job cycle by cycle as host, array stub and result sink, and
  // compares every output against the reference model each cycle.
  task automatic run_job(input int gap_pct, input int rdy_pct, input int res_pct,
                         input bit toggle, input bit noise, input bit stall,
                         input int stick, input bit abort, input int budget);
    bit started = 1'b0, stall_done = 1'b0, load, drain, xfer, pop;
    int cyc = 0, abort_wait = 0, stall_left = 0;
    logic [7:0] exp_v, got_v;
    word_t exp_ad, exp_rd;
    host_q = job_words;
    stub_rx.delete(); res_got.delete();
    res_idx = 0; stub_has_res = 1'b0; busy_cnt = 0; done_cnt = 0; xfer_cnt = 0;
    while (!(started && ph == 0) && cyc < budget) begin
      @(posedge clk); #1; cyc++;
      start_i = (ph == 0 && !started) ? 1'b1 : (noise && ph != 0 && $urandom_range(0, 2) == 0);
      bus.host_valid_i = (host_q.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
      bus.host_data_i  = bus.host_valid_i ? host_q[0] : word_t'($urandom);
      if (stall && !stall_done && ph == 1 && xfer_cnt == 2) begin
        stall_left = 3; stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        bus.arr_ready_i = 1'b0; stall_left--;
      end else begin
        bus.arr_ready_i = ($urandom_range(0, 99) < rdy_pct);
      end
      bus.arr_busy_i = (busy_cnt > 0) || (stick == 1 && ph == 2) || (stick == 2 && ph == 4);
      if (busy_cnt > 0) busy_cnt--;
      bus.arr_valid_i = stub_has_res && (res_idx < res_src.size()) && ($urandom_range(0, 3) != 0);
      bus.arr_data_i  = (res_idx < res_src.size()) ? res_src[res_idx] : word_t'($urandom);
      bus.res_ready_i = toggle ? ~bus.res_ready_i : ($urandom_range(0, 99) < res_pct);
      if (abort && ph == 4) begin
        abort_wait++;
        if (abort_wait == 3) begin
          reset_ni = 1'b0; ph = 0; exp_err = 1'b0;
        end
      end

      @(negedge clk);
      load  = (ph == 1) || (ph == 3);
      drain = (ph == 6);
      exp_v = {ph != 0, ph == 7, exp_err, load & bus.arr_ready_i, load & bus.host_valid_i,
               ph == 5, drain & bus.arr_valid_i & bus.res_ready_i, drain & bus.arr_valid_i};
      got_v = {busy_o, done_o, err_o, bus.host_ready_o, bus.arr_valid_o,
               bus.arr_flush_o, bus.arr_yumi_o, bus.res_valid_o};
      exp_ad = load  ? bus.host_data_i : '0;
      exp_rd = drain ? bus.arr_data_i  : '0;
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL ctrl_outs cyc %0d phase %0d: {busy,done,err,hrdy,avld,flush,yumi,rvld} got %b exp %b",
                 cyc, ph, got_v, exp_v);
      end
      checks++;
      if (bus.arr_data_o !== exp_ad) begin
        errors++;
        $display("FAIL arr_data_o cyc %0d: got %h exp %h", cyc, bus.arr_data_o, exp_ad);
      end
      checks++;
      if (bus.res_data_o !== exp_rd) begin
        errors++;
        $display("FAIL res_data_o cyc %0d: got %h exp %h", cyc, bus.res_data_o, exp_rd);
      end

      // Bus functional models react to what the DUT actually presented.
      if (bus.host_valid_i && bus.host_ready_o && host_q.size() > 0) void'(host_q.pop_front());
      if (bus.arr_valid_o && bus.arr_ready_i) begin
        stub_rx.push_back(bus.arr_data_o);
        if (stub_rx.size() % E == 0) busy_cnt = $urandom_range(0, 3);
      end
      if (bus.arr_flush_o) stub_has_res = 1'b1;
      if (bus.arr_yumi_o) res_idx++;
      if (bus.res_valid_o && bus.res_ready_i) res_got.push_back(bus.res_data_o);
      if (done_o) done_cnt++;

      // Reference model advance.
      xfer = load && bus.host_valid_i && bus.arr_ready_i;
      pop  = drain && bus.arr_valid_i && bus.res_ready_i;
      case (ph)
        0: if (start_i && reset_ni) begin ph = 1; cnt = 0; exp_err = 1'b0; started = 1'b1; end
        1, 3: if (xfer) begin
          cnt++; xfer_cnt++;
          if (cnt == E) begin ph++; cnt = 0; tcnt = 0; end
        end
        2, 4: if (!bus.arr_busy_i) begin
          ph++; tcnt = 0;
        end else begin
          tcnt++;
          if (TIMER_ON && tcnt == TO) begin ph = 0; exp_err = 1'b1; end
        end
        5: begin ph = 6; cnt = 0; tcnt = 0; end
        6: if (pop) begin
          cnt++; tcnt = 0;
          if (cnt == E) ph = 7;
        end else begin
          tcnt++;
          if (TIMER_ON && tcnt == TO) begin ph = 0; exp_err = 1'b1; end
        end
        default: ph = 0;
      endcase
    end
    checks++;
    if (!(started && ph == 0)) begin
      errors++;
      $display("FAIL job_budget: job not finished after %0d cycles (phase %0d)", cyc, ph);
      ph = 0;
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [7:0] got_v;
    reset_ni = 1'b0;
    start_i = 1'b1; bus.host_valid_i = 1'b1; bus.host_data_i = 8'hA5;
    bus.arr_ready_i = 1'b1; bus.arr_busy_i = 1'b1; bus.arr_valid_i = 1'b1;
    bus.arr_data_i = 8'h5A; bus.res_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    got_v = {busy_o, done_o, err_o, bus.host_ready_o, bus.arr_valid_o,
             bus.arr_flush_o, bus.arr_yumi_o, bus.res_valid_o};
    checks++;
    if (got_v !== 8'h00) begin errors++; $display("FAIL reset_outs: got %b exp 00000000", got_v); end
    checks++;
    if (bus.arr_data_o !== 8'h00 || bus.res_data_o !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h/%h exp 00/00", bus.arr_data_o, bus.res_data_o);
    end
    @(posedge clk); #1;
    start_i = 1'b0; reset_ni = 1'b1;
    @(negedge clk);
    got_v = {busy_o, done_o, err_o, bus.host_ready_o, bus.arr_valid_o,
             bus.arr_flush_o, bus.arr_yumi_o, bus.res_valid_o};
    checks++;
    if (got_v !== 8'h00) begin errors++; $display("FAIL idle_outs: got %b exp 00000000", got_v); end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_basic_job();
    word_t a[$] = '{8'd3, 8'd4, 8'd2, 8'd4, 8'd1, 8'd2, 8'd1, 8'd3};
    word_t r[$] = '{8'd7, 8'd10, 8'd15, 8'd22};
    job_words = a; res_src = r;
    run_job(0, 100, 100, 0, 0, 0, 0, 0, 200);
    checks++;
    if (!same_q(stub_rx, a)) begin errors++; $display("FAIL basic_array_words: got %0d words exp 8 in order", stub_rx.size()); end
    checks++;
    if (!same_q(res_got, r)) begin errors++; $display("FAIL basic_results: got %0d words exp 7,10,15,22", res_got.size()); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d pulses exp 1", done_cnt); end
  endtask

  task automatic test_stall();
    new_job(1'b1);
    run_job(40, 80, 100, 0, 0, 1, 0, 0, 400);
    checks++;
    if (!same_q(stub_rx, job_words)) begin errors++; $display("FAIL stall_words: got %0d words exp %0d in order", stub_rx.size(), job_words.size()); end
    checks++;
    if (xfer_cnt != 2 * E) begin errors++; $display("FAIL stall_xfers: got %0d exp %0d", xfer_cnt, 2 * E); end
    checks++;
    if (!same_q(res_got, res_src)) begin errors++; $display("FAIL stall_results: got %0d words exp %0d", res_got.size(), E); end
  endtask

  task automatic test_res_backpressure();
    word_t r[$] = '{8'd7, 8'd10, 8'd15, 8'd22};
    new_job(1'b1); res_src = r;
    run_job(0, 100, 0, 1, 0, 0, 0, 0, 400);
    checks++;
    if (!same_q(res_got, r)) begin errors++; $display("FAIL bp_results: got %0d words exp 7,10,15,22", res_got.size()); end
    checks++;
    if (res_idx != E) begin errors++; $display("FAIL bp_yumi_count: got %0d exp %0d", res_idx, E); end
  endtask

  task automatic test_start_ignored();
    new_job(1'b1);
    run_job(20, 70, 70, 0, 1, 0, 0, 0, 400);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL noise_done: got %0d pulses exp 1", done_cnt); end
    checks++;
    if (!same_q(stub_rx, job_words)) begin errors++; $display("FAIL noise_words: got %0d words exp %0d", stub_rx.size(), job_words.size()); end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL noise_idle_busy: got %b exp 0", busy_o); end
  endtask

  task automatic test_reset_mid_job();
    new_job(1'b1);
    run_job(0, 100, 100, 0, 0, 0, 2, 1, 400);
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d pulses exp 0", done_cnt); end
    reset_ni = 1'b1;
    new_job(1'b1);
    run_job(10, 90, 90, 0, 0, 0, 0, 0, 400);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL after_abort_done: got %0d pulses exp 1", done_cnt); end
    checks++;
    if (!same_q(res_got, res_src)) begin errors++; $display("FAIL after_abort_results: got %0d words exp %0d", res_got.size(), E); end
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 6; j++) begin
      new_job(1'b1);
      run_job($urandom_range(0, 50), $urandom_range(40, 100), $urandom_range(40, 100),
              1'b0, 1'($urandom_range(0, 1)), 1'b0, 0, 1'b0, 600);
      checks++;
      if (!same_q(stub_rx, job_words) || !same_q(res_got, res_src) || done_cnt != 1) begin
        errors++;
        $display("FAIL random_job %0d: words %0d results %0d done %0d exp 8/4/1", j, stub_rx.size(), res_got.size(), done_cnt);
      end
    end
  endtask

`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    new_job(1'b1);
    run_job(0, 100, 100, 0, 0, 0, 1, 0, 400);
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL timeout_done: got %0d pulses exp 0", done_cnt); end
    checks++;
    if (stub_rx.size() != E) begin errors++; $display("FAIL timeout_words: got %0d exp %0d", stub_rx.size(), E); end
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL timeout_flag: err %b busy %b exp 1 0", err_o, busy_o); end
    new_job(1'b1);
    run_job(0, 100, 100, 0, 0, 0, 0, 0, 400);
    checks++;
    if (err_o !== 1'b0 || done_cnt != 1) begin errors++; $display("FAIL timeout_recover: err %b done %0d exp 0 1", err_o, done_cnt); end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_basic_job();
    test_stall();
    test_res_backpressure();
    test_start_ignored();
    test_reset_mid_job();
    test_random_jobs();
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
